ldpc_qc_encoder: RTL and testbench

LDPC_QC_ENCODER -- requirements
Module: ldpc_qc_encoder

---
 rtl/ldpc_qc_encoder_pkg.sv | 25 ++
 rtl/ldpc_qc_encoder_qc_rotate.sv | 29 ++
 rtl/ldpc_qc_encoder.sv | 119 +++++++++++
 tb/tb_ldpc_qc_encoder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_qc_encoder_pkg.sv
// ============================================================================
// Module   : ldpc_qc_encoder_pkg
// Purpose  : Shared defaults, zero-circulant marker and FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ldpc_qc_encoder_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int R_DEF      = 5;
  localparam int C_DEF      = 3;
  localparam int D_DEF      = 8;

  // An all-ones shift marks an all-zero circulant.
  localparam logic [DATA_W_DEF-1:0] ZERO_SHIFT = '1;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_EMIT  = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/ldpc_qc_encoder_qc_rotate.sv
// ============================================================================
// Module   : qc_rotate
// Purpose  : D-bit circulant rotate y[k] = x[(k+s) mod D]; all-ones s gives 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module qc_rotate
  import ldpc_qc_encoder_pkg::*;
#(
  parameter int data_w = DATA_W_DEF,
  parameter int D      = D_DEF
) (
  input  logic [D-1:0]      data_i,
  input  logic [data_w-1:0] shift_i,
  output logic [D-1:0]      data_o
);

  logic [31:0] smod;
  logic [D-1:0] rotated;

  assign smod    = 32'(shift_i) % 32'(D);
  // Left shift by D when smod==0 yields zero, leaving the plain copy intact.
  assign rotated = (data_i >> smod) | (data_i << (32'(D) - smod));
  assign data_o  = (&shift_i) ? '0 : rotated;

endmodule

`default_nettype wire

// File: rtl/ldpc_qc_encoder.sv
// ============================================================================
// Module   : ldpc_qc_encoder
// Purpose  : Streaming QC-LDPC systematic encoder: K info blocks then C parity.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ldpc_qc_encoder
  import ldpc_qc_encoder_pkg::*;
#(
  parameter int data_w = DATA_W_DEF,
  parameter int R      = R_DEF,
  parameter int C      = C_DEF,
  parameter int D      = D_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [data_w*C*(R-C)-1:0] shift_in,
  input  logic [D-1:0]              in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [D-1:0]              out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last
);

  localparam int K     = R - C;
  localparam int CNT_W = (R > 2) ? $clog2(R) : 1;
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(C - 1);

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [data_w*C*K-1:0]   shift_q;
  logic [D-1:0]            acc_q [C];
  logic [D-1:0]            rot   [C];
  logic [D-1:0]            emit_blk;
  logic                    first_blk;
  logic                    accept;
  logic                    emit_load;

  assign first_blk = (cnt_q == '0);
  assign in_ready  = (state_q == ST_ACCUM) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign emit_load = (state_q == ST_EMIT) && (!out_valid || out_ready);

  // Block 0 takes its shifts straight from the port; later blocks use the copy.
  for (genvar i = 0; i < C; i++) begin : g_row
    logic [data_w-1:0] row_shift;
    assign row_shift = first_blk ? shift_in[(i*K)*data_w +: data_w]
                                 : shift_q[(i*K + int'(cnt_q))*data_w +: data_w];
    qc_rotate #(.data_w(data_w), .D(D)) u_rot (
      .data_i  (in_data),
      .shift_i (row_shift),
      .data_o  (rot[i])
    );
  end

  always_comb begin
    emit_blk = '0;
    for (int i = 0; i < C; i++) begin
      if (cnt_q == CNT_W'(i)) emit_blk = acc_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_ACCUM;
      cnt_q     <= '0;
      shift_q   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      for (int i = 0; i < C; i++) acc_q[i] <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      case (state_q)
        ST_ACCUM: begin
          if (accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            for (int i = 0; i < C; i++)
              acc_q[i] <= first_blk ? rot[i] : (acc_q[i] ^ rot[i]);
            if (first_blk) shift_q <= shift_in;
            if (cnt_q == K_LAST) begin
              state_q <= ST_EMIT;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (emit_load) begin
            out_data  <= emit_blk;
            out_valid <= 1'b1;
            if (cnt_q == C_LAST) begin
              out_last <= 1'b1;
              state_q  <= ST_ACCUM;
              cnt_q    <= '0;
            end else begin
              out_last <= 1'b0;
              cnt_q    <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_ACCUM;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ldpc_qc_encoder.sv
// ============================================================================
// Module   : tb_ldpc_qc_encoder
// Purpose  : Directed and randomized self-checking bench for ldpc_qc_encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ldpc_qc_encoder;
  import ldpc_qc_encoder_pkg::*;

  localparam int DW = 8;
  localparam int R  = 5;
  localparam int C  = 3;
  localparam int D  = 8;
  localparam int K  = R - C;
  localparam logic [7:0] Z = ZERO_SHIFT;

  logic               clk = 1'b0;
  logic               rst;
  logic [DW*C*K-1:0]  shift_in;
  logic [D-1:0]       in_data;
  logic               in_valid;
  logic               in_ready;
  logic [D-1:0]       out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;

  typedef struct {
    int         cyc;
    logic       last;
    logic [7:0] data;
  } obs_t;

  obs_t       q[$];
  logic [7:0] expq[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         rnd_ready = 1'b0;

  ldpc_qc_encoder #(.data_w(DW), .R(R), .C(C), .D(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .shift_in  (shift_in),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (rst && out_valid && out_ready) q.push_back('{cyc, out_last, out_data});

  always @(posedge clk)
    if (rnd_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end

  function automatic logic [47:0] pack(input logic [7:0] s00, s01, s10, s11, s20, s21);
    return {s21, s20, s11, s10, s01, s00};
  endfunction

  function automatic logic [7:0] rotm(input logic [7:0] x, input logic [7:0] s);
    logic [7:0] y;
    int sm;
    y = '0;
    if (s == Z) return y;
    sm = int'(s) % 8;
    for (int k = 0; k < 8; k++) y[k] = x[(k + sm) % 8];
    return y;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    bit ok;
    in_data  = d;
    in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      ok = in_ready;
      step();
      if (ok) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    checks++; errors++;
    $display("FAIL send_timeout block=%h never accepted", d);
  endtask

  task automatic wait_out(input int n, input string nm);
    for (int t = 0; t < 300; t++) begin
      if (q.size() >= n) return;
      step();
    end
    checks++; errors++;
    $display("FAIL %s_timeout got %0d blocks need %0d", nm, q.size(), n);
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    shift_in = pack(8'd0, 8'd1, Z, 8'd0, Z, Z);
    #12 rst = 1'b1;
    step();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b need 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h need 00", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b need 0", out_last); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b need 1", in_ready); end
    step();
  endtask

  task automatic test_basic();
    logic [7:0] e[5] = '{8'h01, 8'h01, 8'h81, 8'h01, 8'h00};
    q.delete();
    shift_in = pack(8'd0, 8'd1, Z, 8'd0, Z, Z);
    send(8'h01);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h01) begin
      errors++; $display("FAIL basic_latency got v=%b d=%h need v=1 d=01", out_valid, out_data);
    end
    step();
    send(8'h01);
    wait_out(5, "basic");
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (q[k].data !== e[k] || q[k].last !== (k == 4)) begin
        errors++; $display("FAIL basic_blk%0d got %h/%b need %h/%b", k, q[k].data, q[k].last, e[k], (k == 4));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] m[6] = '{8'h01, 8'h01, 8'h02, 8'h00, 8'h80, 8'h03};
    logic [7:0] e[15] = '{8'h01, 8'h01, 8'h81, 8'h01, 8'h00,
                          8'h02, 8'h00, 8'h02, 8'h00, 8'h00,
                          8'h80, 8'h03, 8'h01, 8'h03, 8'h00};
    q.delete();
    out_ready = 1'b1;
    shift_in = pack(8'd0, 8'd1, Z, 8'd0, Z, Z);
    for (int k = 0; k < 6; k++) send(m[k]);
    wait_out(15, "b2b");
    for (int k = 0; k < 15; k++) begin
      checks++;
      if (q[k].data !== e[k] || q[k].last !== ((k % 5) == 4) || q[k].cyc !== q[0].cyc + k) begin
        errors++;
        $display("FAIL b2b_blk%0d got %h/%b cyc+%0d need %h/%b cyc+%0d",
                 k, q[k].data, q[k].last, q[k].cyc - q[0].cyc, e[k], ((k % 5) == 4), k);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] e[5] = '{8'h01, 8'h01, 8'h81, 8'h01, 8'h00};
    q.delete();
    out_ready = 1'b1;
    shift_in = pack(8'd0, 8'd1, Z, 8'd0, Z, Z);
    send(8'h01);
    send(8'h01);
    step();
    step();
    out_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h01 || in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d got v=%b d=%h rdy=%b need v=1 d=01 rdy=0", t, out_valid, out_data, in_ready);
      end
      step();
    end
    checks++;
    if (q.size() !== 3) begin errors++; $display("FAIL stall_count got %0d need 3", q.size()); end
    out_ready = 1'b1;
    wait_out(5, "stall");
    step();
    checks++;
    if (q.size() !== 5) begin errors++; $display("FAIL stall_total got %0d need 5", q.size()); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (q[k].data !== e[k] || q[k].last !== (k == 4)) begin
        errors++; $display("FAIL stall_blk%0d got %h/%b need %h/%b", k, q[k].data, q[k].last, e[k], (k == 4));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e[5] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00};
    q.delete();
    out_ready = 1'b1;
    shift_in = pack(8'd0, 8'd1, Z, 8'd0, Z, Z);
    send(8'h55);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got v=%b d=%h l=%b need 0/00/0", out_valid, out_data, out_last);
    end
    #2 rst = 1'b1;
    step();
    q.delete();
    send(8'hFF);
    send(8'h00);
    wait_out(5, "midrst");
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (q[k].data !== e[k] || q[k].last !== (k == 4)) begin
        errors++; $display("FAIL midrst_blk%0d got %h/%b need %h/%b", k, q[k].data, q[k].last, e[k], (k == 4));
      end
    end
  endtask

  task automatic test_shift_sample();
    logic [7:0] e[5] = '{8'h01, 8'h01, 8'h81, 8'h01, 8'h00};
    q.delete();
    out_ready = 1'b1;
    shift_in = pack(8'd0, 8'd9, Z, 8'd0, Z, Z);
    send(8'h01);
    shift_in = pack(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    send(8'h01);
    wait_out(5, "sample");
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (q[k].data !== e[k] || q[k].last !== (k == 4)) begin
        errors++; $display("FAIL sample_blk%0d got %h/%b need %h/%b", k, q[k].data, q[k].last, e[k], (k == 4));
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] s[6];
    logic [7:0] m0, m1;
    int n;
    q.delete();
    expq.delete();
    rnd_ready = 1'b1;
    for (int cw = 0; cw < 6; cw++) begin
      for (int k = 0; k < 6; k++)
        s[k] = ($urandom_range(0, 3) == 0) ? Z : 8'($urandom_range(0, 20));
      m0 = 8'($urandom);
      m1 = 8'($urandom);
      shift_in = pack(s[0], s[1], s[2], s[3], s[4], s[5]);
      expq.push_back(m0);
      expq.push_back(m1);
      expq.push_back(rotm(m0, s[0]) ^ rotm(m1, s[1]));
      expq.push_back(rotm(m0, s[2]) ^ rotm(m1, s[3]));
      expq.push_back(rotm(m0, s[4]) ^ rotm(m1, s[5]));
      send(m0);
      shift_in = 48'($urandom) ^ {16'($urandom), 32'h0};
      n = $urandom_range(0, 2);
      for (int g = 0; g < n; g++) step();
      send(m1);
    end
    rnd_ready = 1'b0;
    step();
    step();
    out_ready = 1'b1;
    wait_out(30, "random");
    for (int k = 0; k < 30; k++) begin
      checks++;
      if (q[k].data !== expq[k] || q[k].last !== ((k % 5) == 4)) begin
        errors++; $display("FAIL random_blk%0d got %h/%b need %h/%b", k, q[k].data, q[k].last, expq[k], ((k % 5) == 4));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_shift_sample();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
